// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receiver and transmitter:
//   - uart_state_t    : receiver FSM state encoding
//   - PAR_* constants : encoding of the 2-bit parity-mode input
//   - calc_tick_rate  : system clocks per oversample tick
// Optional feature macro: UART_RX_PARITY_EN (adds the PARITY state).
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        RECOVER
    } uart_state_t;

    localparam logic [1:0] PAR_NONE  = 2'b00;
    localparam logic [1:0] PAR_EVEN  = 2'b01;
    localparam logic [1:0] PAR_ODD   = 2'b10;
    localparam logic [1:0] PAR_NONE2 = 2'b11;

    function automatic int calc_tick_rate(input int sys_clock,
                                          input int baud_rate,
                                          input int oversample);
        return sys_clock / (baud_rate * oversample);
    endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// -----------------------------------------------------------------------------
// uart_rx_param_if
// Received-word bus of the UART receiver.
//   o_rx_data       : received word, LSB received first
//   o_rx_data_valid : one-cycle pulse per completed frame
//   o_parity_err    : parity check failed (valid with o_rx_data_valid)
//   o_frame_err     : a stop bit read as 0 (valid with o_rx_data_valid)
//   o_break         : whole frame read as 0 (valid with o_rx_data_valid)
//   o_busy          : receiver is not idle
// Modports: master = receiver side (drives), slave = consumer side.
// -----------------------------------------------------------------------------
interface uart_rx_param_if #(
    parameter int NB_DATA = 8
);
    logic [NB_DATA-1:0] o_rx_data;
    logic               o_rx_data_valid;
    logic               o_parity_err;
    logic               o_frame_err;
    logic               o_break;
    logic               o_busy;

    modport master (
        output o_rx_data, o_rx_data_valid, o_parity_err,
               o_frame_err, o_break, o_busy
    );

    modport slave (
        input  o_rx_data, o_rx_data_valid, o_parity_err,
               o_frame_err, o_break, o_busy
    );
endinterface

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
// Oversample tick generator shared by the UART receiver and transmitter.
// Counts 0..TICK_RATE-1 and pulses o_tick for one cycle at the terminal count.
// Ports:
//   i_clock : clock, rising edge
//   i_reset : asynchronous active-low reset
//   i_clear : synchronous restart of the count from 0
//   o_tick  : one-cycle tick pulse
// -----------------------------------------------------------------------------
module uart_baud_gen #(
    parameter int TICK_RATE = 651
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_clear,
    output logic o_tick
);
    localparam int CNT_W = (TICK_RATE > 1) ? $clog2(TICK_RATE) : 1;
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(TICK_RATE - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            count <= '0;
        end else if (i_clear || count == TERMINAL) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    // A clear cycle suppresses the tick so a restarted bit never sees a stale one
    assign o_tick = (count == TERMINAL) && !i_clear;

endmodule

// File: rtl/uart_rx_param.sv
// -----------------------------------------------------------------------------
// uart_rx_param
// Parameterised UART receiver with 2-of-3 majority mid-bit sampling, optional
// parity, 1 or 2 stop bits, frame-error / break detection and line recovery.
// Ports:
//   i_clock       : clock, rising edge
//   i_reset       : asynchronous active-low reset
//   i_rx          : asynchronous serial line, idles high
//   i_parity_mode : 00 none, 01 even, 10 odd, 11 none
//   rx_out        : uart_rx_param_if.master, received word and status
// Optional feature macro: UART_RX_PARITY_EN. Without it the frame carries no
// parity bit, i_parity_mode is ignored and o_parity_err is constant 0.
// -----------------------------------------------------------------------------
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int NB_DATA    = 8,
    parameter int NB_STOP    = 1,
    parameter int OVERSAMPLE = 16,
    parameter int SYS_CLOCK  = 100000000,
    parameter int BAUD_RATE  = 9600
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_rx,
    input  logic [1:0] i_parity_mode,
    uart_rx_param_if.master rx_out
);
    localparam int TICK_RATE = calc_tick_rate(SYS_CLOCK, BAUD_RATE, OVERSAMPLE);
    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_FIRST = OS_W'(OVERSAMPLE/2 - 1);
    localparam logic [OS_W-1:0] OS_MID   = OS_W'(OVERSAMPLE/2);
    localparam logic [OS_W-1:0] OS_LAST  = OS_W'(OVERSAMPLE/2 + 1);
    localparam logic [OS_W-1:0] OS_END   = OS_W'(OVERSAMPLE - 1);

    uart_state_t        state, next_state;
    logic               rx_meta, rx_sync, rx_prev;
    logic               tick, baud_clear;
    logic [OS_W-1:0]    os_cnt;
    logic [1:0]         samples;
    logic [3:0]         bit_cnt;
    logic               stop_idx;
    logic [NB_DATA-1:0] shift_reg;
    logic               all_zero, frame_bad;
    logic [NB_DATA-1:0] rx_data;
    logic               rx_valid, frame_err, brk;
    logic               fall_edge, s_first, s_mid, s_last, bit_end;
    logic               maj, last_stop, frame_err_now;
`ifdef UART_RX_PARITY_EN
    logic [1:0]         mode_latched;
    logic               par_acc, par_err_acc, par_err, parity_en;
`else
    logic               unused_parity_mode;
    assign unused_parity_mode = ^i_parity_mode;
`endif

    uart_baud_gen #(.TICK_RATE(TICK_RATE)) u_baud_gen (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_clear (baud_clear),
        .o_tick  (tick)
    );

    // Sample-point decode; the third sample is the live synchronized value
    assign fall_edge     = rx_prev && !rx_sync;
    assign s_first       = tick && (os_cnt == OS_FIRST);
    assign s_mid         = tick && (os_cnt == OS_MID);
    assign s_last        = tick && (os_cnt == OS_LAST);
    assign bit_end       = tick && (os_cnt == OS_END);
    assign maj           = (samples[0] & samples[1]) | ((samples[0] | samples[1]) & rx_sync);
    assign last_stop     = (NB_STOP == 1) || stop_idx;
    assign frame_err_now = frame_bad || !maj;
`ifdef UART_RX_PARITY_EN
    assign parity_en     = (mode_latched == PAR_EVEN) || (mode_latched == PAR_ODD);
`endif

    // FSM state register
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) state <= IDLE;
        else          state <= next_state;
    end

    // Next-state logic; START decides at the third sample so glitches release
    // early, while DATA/PARITY advance on bit boundaries and STOP finishes at
    // its final sample to allow back-to-back frames
    always_comb begin
        next_state = state;
        baud_clear = 1'b0;
        case (state)
            IDLE: begin
                if (fall_edge) begin
                    next_state = START;
                    baud_clear = 1'b1;
                end
            end
            START: begin
                if (s_last && maj)  next_state = IDLE;
                else if (bit_end)   next_state = DATA;
            end
            DATA: begin
                if (bit_end && bit_cnt == 4'(NB_DATA)) begin
`ifdef UART_RX_PARITY_EN
                    next_state = parity_en ? PARITY : STOP;
`else
                    next_state = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bit_end) next_state = STOP;
            end
`endif
            STOP: begin
                if (s_last && last_stop) next_state = frame_err_now ? RECOVER : IDLE;
            end
            RECOVER: begin
                if (rx_sync) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Synchronizer, oversample counter and frame datapath
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_prev   <= 1'b1;
            os_cnt    <= '0;
            samples   <= '0;
            bit_cnt   <= '0;
            stop_idx  <= 1'b0;
            shift_reg <= '0;
            all_zero  <= 1'b0;
            frame_bad <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            brk       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            mode_latched <= PAR_NONE;
            par_acc      <= 1'b0;
            par_err_acc  <= 1'b0;
            par_err      <= 1'b0;
`endif
        end else begin
            rx_meta  <= i_rx;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            rx_valid <= 1'b0;
            if (baud_clear)    os_cnt <= '0;
            else if (bit_end)  os_cnt <= '0;
            else if (tick)     os_cnt <= os_cnt + 1'b1;
            if (s_first) samples[0] <= rx_sync;
            if (s_mid)   samples[1] <= rx_sync;
            case (state)
                IDLE: begin
                    if (fall_edge) begin
                        bit_cnt   <= '0;
                        stop_idx  <= 1'b0;
                        all_zero  <= 1'b1;
                        frame_bad <= 1'b0;
`ifdef UART_RX_PARITY_EN
                        mode_latched <= i_parity_mode;
                        par_acc      <= 1'b0;
                        par_err_acc  <= 1'b0;
`endif
                    end
                end
                DATA: begin
                    if (s_last) begin
                        shift_reg <= {maj, shift_reg[NB_DATA-1:1]};
                        bit_cnt   <= bit_cnt + 1'b1;
                        all_zero  <= all_zero & ~maj;
`ifdef UART_RX_PARITY_EN
                        par_acc   <= par_acc ^ maj;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (s_last) begin
                        par_err_acc <= (mode_latched == PAR_ODD) ? ~(par_acc ^ maj) : (par_acc ^ maj);
                        all_zero    <= all_zero & ~maj;
                    end
                end
`endif
                STOP: begin
                    if (s_last && !last_stop) begin
                        frame_bad <= frame_err_now;
                        all_zero  <= all_zero & ~maj;
                    end
                    if (bit_end && !last_stop) stop_idx <= 1'b1;
                    // Only the first stop bit takes part in break detection
                    if (s_last && last_stop) begin
                        rx_data   <= shift_reg;
                        rx_valid  <= 1'b1;
                        frame_err <= frame_err_now;
                        brk       <= stop_idx ? all_zero : (all_zero & ~maj);
`ifdef UART_RX_PARITY_EN
                        par_err   <= par_err_acc;
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rx_out.o_rx_data       = rx_data;
    assign rx_out.o_rx_data_valid = rx_valid;
    assign rx_out.o_frame_err     = frame_err;
    assign rx_out.o_break         = brk;
    assign rx_out.o_busy          = (state != IDLE);
`ifdef UART_RX_PARITY_EN
    assign rx_out.o_parity_err    = par_err;
`else
    assign rx_out.o_parity_err    = 1'b0;
`endif

endmodule
